coin_acceptor: RTL and testbench

COIN_ACCEPTOR -- requirements
Module: coin_acceptor

---
 rtl/coin_acceptor.sv | 143 ++++++++++++++
 tb/tb_coin_acceptor.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/coin_acceptor.sv
// Vending-machine coin acceptor. Collects 1/2/5 yuan coins against a latched
// amount due, then reports change on success or a full refund on cancel/timeout.
module coin_acceptor #(
  parameter longint unsigned CLK_HZ    = 100_000_000,
  parameter longint unsigned TIMEOUT_S = 30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_p,
  input  logic [5:0] shouldpay,
  input  logic [2:0] money,
  input  logic       cancel,
  output logic [3:0] paid1,
  output logic [3:0] paid10,
  output logic [3:0] payback1,
  output logic [3:0] payback10,
  output logic       success,
  output logic       successpay,
  output logic       refund,
  output logic       busy
);

  localparam longint unsigned LIMIT = CLK_HZ * TIMEOUT_S - 1;
  localparam int TW = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;
  localparam logic [TW-1:0] LIMIT_T = TW'(LIMIT);

  typedef enum logic [1:0] {IDLE, COLLECT, SUCCESS, REFUND} state_t;

  state_t        state_q;
  logic [5:0]    due_q;
  logic [5:0]    paid_q;
  logic [5:0]    payback_q;
  logic [TW-1:0] timer_q;
  logic          success_q, successpay_q, refund_q, busy_q;

  // History registers remember "was low last cycle", so a level that is already
  // high when reset releases cannot masquerade as a press.
  logic          enLow_q;
  logic          cancelLow_q;
  logic [2:0]    moneyLow_q;

  logic          enRise_d;
  logic          cancelRise_d;
  logic [2:0]    coinRise_d;
  logic [2:0]    coinVal_d;
  logic [6:0]    paidSum_d;
  logic [5:0]    paidNext_d;
  logic          timeout_d;

  assign enRise_d     = en_p & enLow_q;
  assign cancelRise_d = cancel & cancelLow_q;
  assign coinRise_d   = money & moneyLow_q;
  assign timeout_d    = (timer_q == LIMIT_T);

  // Simultaneous presses of different coins are ambiguous and add nothing.
  always_comb begin
    coinVal_d = 3'd0;
    case (coinRise_d)
      3'b001:  coinVal_d = 3'd1;
      3'b010:  coinVal_d = 3'd2;
      3'b100:  coinVal_d = 3'd5;
      default: coinVal_d = 3'd0;
    endcase
  end

  assign paidSum_d  = {1'b0, paid_q} + {4'b0000, coinVal_d};
  assign paidNext_d = (paidSum_d > 7'd63) ? 6'd63 : paidSum_d[5:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      due_q        <= '0;
      paid_q       <= '0;
      payback_q    <= '0;
      timer_q      <= '0;
      success_q    <= 1'b0;
      successpay_q <= 1'b0;
      refund_q     <= 1'b0;
      busy_q       <= 1'b0;
      enLow_q      <= 1'b0;
      cancelLow_q  <= 1'b0;
      moneyLow_q   <= '0;
    end else begin
      enLow_q     <= ~en_p;
      cancelLow_q <= ~cancel;
      moneyLow_q  <= ~money;
      success_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          paid_q    <= '0;
          payback_q <= '0;
          if (enRise_d && shouldpay != 6'd0) begin
            due_q   <= shouldpay;
            timer_q <= '0;
            busy_q  <= 1'b1;
            state_q <= COLLECT;
          end
        end
        COLLECT: begin
          // Abort conditions win over a coin arriving in the same cycle.
          if (cancelRise_d || timeout_d || !en_p) begin
            payback_q <= paid_q;
            busy_q    <= 1'b0;
            refund_q  <= 1'b1;
            state_q   <= REFUND;
          end else begin
            timer_q <= timer_q + TW'(1);
            if (coinVal_d != 3'd0) begin
              paid_q <= paidNext_d;
              if (paidNext_d >= due_q) begin
                payback_q    <= paidNext_d - due_q;
                success_q    <= 1'b1;
                successpay_q <= 1'b1;
                busy_q       <= 1'b0;
                state_q      <= SUCCESS;
              end
            end
          end
        end
        SUCCESS, REFUND: begin
          if (!en_p) begin
            paid_q       <= '0;
            payback_q    <= '0;
            successpay_q <= 1'b0;
            refund_q     <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign paid10     = 4'(paid_q / 6'd10);
  assign paid1      = 4'(paid_q % 6'd10);
  assign payback10  = 4'(payback_q / 6'd10);
  assign payback1   = 4'(payback_q % 6'd10);
  assign success    = success_q;
  assign successpay = successpay_q;
  assign refund     = refund_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor: a main instance with a long payment window
// and a second one with CLK_HZ=10, TIMEOUT_S=3 for the timeout scenario.
module tb_coin_acceptor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en_p;
  logic [5:0] shouldpay;
  logic [2:0] money;
  logic       cancel;

  logic [3:0] paid1, paid10, payback1, payback10;
  logic       success, successpay, refund, busy;
  logic [3:0] paid1T, paid10T, payback1T, payback10T;
  logic       successT, successpayT, refundT, busyT;

  int compared = 0;
  int mismatched = 0;
  int successSeen = 0;

  coin_acceptor #(.CLK_HZ(1000), .TIMEOUT_S(1)) dut (
    .clk(clk), .rst_n(rst_n), .en_p(en_p), .shouldpay(shouldpay), .money(money),
    .cancel(cancel), .paid1(paid1), .paid10(paid10), .payback1(payback1),
    .payback10(payback10), .success(success), .successpay(successpay),
    .refund(refund), .busy(busy)
  );

  coin_acceptor #(.CLK_HZ(10), .TIMEOUT_S(3)) dutT (
    .clk(clk), .rst_n(rst_n), .en_p(en_p), .shouldpay(shouldpay), .money(money),
    .cancel(cancel), .paid1(paid1T), .paid10(paid10T), .payback1(payback1T),
    .payback10(payback10T), .success(successT), .successpay(successpayT),
    .refund(refundT), .busy(busyT)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (success === 1'b1) successSeen++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pressCoin(input logic [2:0] bits);
    money = bits;
    tick();
    money = 3'b000;
    tick();
  endtask

  task automatic endSession();
    money  = 3'b000;
    cancel = 1'b0;
    en_p   = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en_p = 1'b0; shouldpay = '0; money = '0; cancel = 1'b0;
    #12;
    compared++;
    if ({paid10, paid1, payback10, payback1, success, successpay, refund, busy} !== 20'h0) begin
      mismatched++;
      $display("[TB] FAIL reset_outputs: got %h expected 0",
               {paid10, paid1, payback10, payback1, success, successpay, refund, busy});
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_zero_due();
    shouldpay = 6'd0; en_p = 1'b1;
    tick();
    compared++;
    if (busy !== 1'b0) begin
      mismatched++; $display("[TB] FAIL zero_due_busy: got %b expected 0", busy);
    end
    pressCoin(3'b100);
    compared++;
    if ({paid10, paid1} !== 8'h00) begin
      mismatched++; $display("[TB] FAIL idle_coin_paid: got %h expected 00", {paid10, paid1});
    end
    endSession();
  endtask

  task automatic test_success();
    successSeen = 0;
    shouldpay = 6'd6; en_p = 1'b1;
    tick();
    compared++;
    if (busy !== 1'b1) begin
      mismatched++; $display("[TB] FAIL success_busy: got %b expected 1", busy);
    end
    pressCoin(3'b100);
    money = 3'b010;
    tick();
    compared++;
    if ({success, successpay, busy, paid10, paid1, payback10, payback1} !== {3'b110, 16'h0701}) begin
      mismatched++;
      $display("[TB] FAIL success_complete: got %h expected %h",
               {success, successpay, busy, paid10, paid1, payback10, payback1}, {3'b110, 16'h0701});
    end
    money = 3'b000;
    tick();
    compared++;
    if ({success, successpay, paid10, paid1, payback1} !== {2'b01, 12'h071}) begin
      mismatched++;
      $display("[TB] FAIL success_hold: got %h expected %h",
               {success, successpay, paid10, paid1, payback1}, {2'b01, 12'h071});
    end
    en_p = 1'b0;
    tick();
    compared++;
    if ({paid10, paid1, payback10, payback1, success, successpay, refund, busy} !== 20'h0) begin
      mismatched++;
      $display("[TB] FAIL success_to_idle: got %h expected 0",
               {paid10, paid1, payback10, payback1, success, successpay, refund, busy});
    end
    compared++;
    if (successSeen !== 1) begin
      mismatched++; $display("[TB] FAIL success_pulse_len: got %0d expected 1", successSeen);
    end
    endSession();
  endtask

  task automatic test_cancel();
    successSeen = 0;
    shouldpay = 6'd14; en_p = 1'b1;
    tick();
    pressCoin(3'b100);
    pressCoin(3'b100);
    cancel = 1'b1;
    tick();
    compared++;
    if ({refund, busy, paid10, paid1, payback10, payback1} !== {2'b10, 16'h1010}) begin
      mismatched++;
      $display("[TB] FAIL cancel_refund: got %h expected %h",
               {refund, busy, paid10, paid1, payback10, payback1}, {2'b10, 16'h1010});
    end
    compared++;
    if (successSeen !== 0) begin
      mismatched++; $display("[TB] FAIL cancel_no_success: got %0d expected 0", successSeen);
    end
    endSession();
  endtask

  task automatic test_timeout();
    shouldpay = 6'd9; en_p = 1'b1;
    tick();
    pressCoin(3'b010);
    for (int i = 0; i < 27; i++) tick();
    compared++;
    if ({refundT, busyT} !== 2'b01) begin
      mismatched++; $display("[TB] FAIL timeout_early: got %b expected 01", {refundT, busyT});
    end
    tick();
    compared++;
    if ({refundT, busyT, payback10T, payback1T} !== {2'b10, 8'h02}) begin
      mismatched++;
      $display("[TB] FAIL timeout_refund: got %h expected %h",
               {refundT, busyT, payback10T, payback1T}, {2'b10, 8'h02});
    end
    compared++;
    if ({refund, busy, paid1} !== {2'b01, 4'd2}) begin
      mismatched++; $display("[TB] FAIL long_window_still_collecting: got %h expected %h",
                             {refund, busy, paid1}, {2'b01, 4'd2});
    end
    en_p = 1'b0;
    tick();
    compared++;
    if ({refund, payback10, payback1} !== {1'b1, 8'h02}) begin
      mismatched++; $display("[TB] FAIL en_low_refund: got %h expected %h",
                             {refund, payback10, payback1}, {1'b1, 8'h02});
    end
    endSession();
  endtask

  task automatic test_coin_vs_cancel();
    successSeen = 0;
    shouldpay = 6'd5; en_p = 1'b1;
    tick();
    money = 3'b100; cancel = 1'b1;
    tick();
    compared++;
    if ({refund, successpay, paid10, paid1, payback10, payback1} !== {2'b10, 16'h0000}) begin
      mismatched++;
      $display("[TB] FAIL coin_vs_cancel: got %h expected %h",
               {refund, successpay, paid10, paid1, payback10, payback1}, {2'b10, 16'h0000});
    end
    compared++;
    if (successSeen !== 0) begin
      mismatched++; $display("[TB] FAIL coin_vs_cancel_success: got %0d expected 0", successSeen);
    end
    endSession();
  endtask

  task automatic test_multi_and_hold();
    shouldpay = 6'd20; en_p = 1'b1;
    tick();
    pressCoin(3'b011);
    compared++;
    if ({paid10, paid1} !== 8'h00) begin
      mismatched++; $display("[TB] FAIL two_coins_ignored: got %h expected 00", {paid10, paid1});
    end
    money = 3'b001;
    for (int i = 0; i < 110; i++) tick();
    compared++;
    if ({busy, paid10, paid1} !== {1'b1, 8'h01}) begin
      mismatched++; $display("[TB] FAIL held_coin_once: got %h expected %h",
                             {busy, paid10, paid1}, {1'b1, 8'h01});
    end
    endSession();
  endtask

  task automatic test_saturation();
    shouldpay = 6'd63; en_p = 1'b1;
    tick();
    for (int i = 0; i < 12; i++) pressCoin(3'b100);
    compared++;
    if ({busy, paid10, paid1} !== {1'b1, 8'h60}) begin
      mismatched++; $display("[TB] FAIL sat_before: got %h expected %h",
                             {busy, paid10, paid1}, {1'b1, 8'h60});
    end
    pressCoin(3'b100);
    compared++;
    if ({successpay, paid10, paid1, payback10, payback1} !== {1'b1, 16'h6300}) begin
      mismatched++;
      $display("[TB] FAIL sat_success: got %h expected %h",
               {successpay, paid10, paid1, payback10, payback1}, {1'b1, 16'h6300});
    end
    endSession();
  endtask

  task automatic test_reset_mid();
    shouldpay = 6'd9; en_p = 1'b1;
    tick();
    pressCoin(3'b100);
    pressCoin(3'b010);
    compared++;
    if ({busy, paid10, paid1} !== {1'b1, 8'h07}) begin
      mismatched++; $display("[TB] FAIL mid_setup: got %h expected %h", {busy, paid10, paid1}, {1'b1, 8'h07});
    end
    #2;
    rst_n = 1'b0;
    #2;
    compared++;
    if ({paid10, paid1, payback10, payback1, success, successpay, refund, busy} !== 20'h0) begin
      mismatched++;
      $display("[TB] FAIL mid_reset_outputs: got %h expected 0",
               {paid10, paid1, payback10, payback1, success, successpay, refund, busy});
    end
    tick();
    rst_n = 1'b1;
    tick(); tick(); tick();
    pressCoin(3'b100);
    compared++;
    if ({busy, paid10, paid1} !== 9'h000) begin
      mismatched++; $display("[TB] FAIL no_session_after_reset: got %h expected 000", {busy, paid10, paid1});
    end
    en_p = 1'b0;
    tick();
    en_p = 1'b1;
    tick();
    compared++;
    if (busy !== 1'b1) begin
      mismatched++; $display("[TB] FAIL session_after_toggle: got %b expected 1", busy);
    end
    endSession();
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_zero_due();
    test_success();
    test_cancel();
    test_timeout();
    test_coin_vs_cancel();
    test_multi_and_hold();
    test_saturation();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
